// File: rtl/spike_dispatcher.sv
// spike_dispatcher
//   Transmit side of the neuron spike path. Each set bit of the per-timestep
//   spike vector becomes one NoC packet {NODE_ID, timestep, neuron_idx},
//   sent lowest neuron index first over a valid/ready handshake.
//   Also keeps the local timestep count, advanced on each rising edge of clear.
// Ports
//   CLK, RESET     rising-edge clock, asynchronous active-high reset
//   clear          timestep start pulse (rising edge advances ts_count)
//   spike_strobe   spike_vec valid this cycle
//   spike_vec      bit i = neuron i spiked
//   pkt_data       {NODE_ID, ts, neuron_idx}
//   pkt_valid      pkt_data valid; held until pkt_ready
//   pkt_ready      router accepts when pkt_valid & pkt_ready at CLK edge
//   busy           FSM not idle
//   ts_done        1-cycle pulse when the last packet of a burst is accepted
//   overrun        sticky: spike arrived for a neuron still pending
//   ts_count       current timestep number
module spike_dispatcher #(
    parameter int NUM_NEURONS = 8,
    parameter int NODE_ID_W   = 4,
    parameter int NODE_ID     = 0,
    parameter int TS_W        = 8,
    localparam int IDX_W      = $clog2(NUM_NEURONS),
    localparam int PKT_W      = NODE_ID_W + TS_W + IDX_W
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   clear,
    input  logic                   spike_strobe,
    input  logic [NUM_NEURONS-1:0] spike_vec,
    output logic [PKT_W-1:0]       pkt_data,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic                   busy,
    output logic                   ts_done,
    output logic                   overrun,
    output logic [TS_W-1:0]        ts_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [NUM_NEURONS-1:0] pending, pending_n, pending_clr;
    logic [TS_W-1:0]        ts_latched, ts_latched_n;
    logic [PKT_W-1:0]       pkt_data_n;
    logic                   pkt_valid_n;
    logic                   ts_done_n;
    logic                   overrun_n;
    logic [IDX_W-1:0]       idx;
    logic                   clear_d;

    assign busy = (state != IDLE);

    // Timestep counter: rising-edge detect on clear, wraps naturally.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clear_d  <= 1'b0;
            ts_count <= '0;
        end else begin
            clear_d <= clear;
            if (clear && !clear_d)
                ts_count <= ts_count + 1'b1;
        end
    end

    // Lowest set bit of pending: scan from the top so the lowest index wins.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
            if (pending[IDX_W'(NUM_NEURONS - 1 - i)])
                idx = IDX_W'(NUM_NEURONS - 1 - i);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            pending    <= '0;
            ts_latched <= '0;
            pkt_data   <= '0;
            pkt_valid  <= 1'b0;
            ts_done    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            pending    <= pending_n;
            ts_latched <= ts_latched_n;
            pkt_data   <= pkt_data_n;
            pkt_valid  <= pkt_valid_n;
            ts_done    <= ts_done_n;
            overrun    <= overrun_n;
        end
    end

    always_comb begin
        state_n      = state;
        pending_n    = pending;
        pending_clr  = pending;
        ts_latched_n = ts_latched;
        pkt_data_n   = pkt_data;
        pkt_valid_n  = pkt_valid;
        ts_done_n    = 1'b0;
        overrun_n    = overrun;

        case (state)
            IDLE: begin
                if (spike_strobe && (spike_vec != '0)) begin
                    pending_n    = spike_vec;
                    ts_latched_n = ts_count;
                    state_n      = SCAN;
                end
            end
            SCAN: begin
                pkt_data_n  = {NODE_ID_W'(NODE_ID), ts_latched, idx};
                pkt_valid_n = 1'b1;
                pending_clr = pending & ~(NUM_NEURONS'(1) << idx);
                pending_n   = pending_clr;
                state_n     = SEND;
            end
            SEND: begin
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Merge a strobe arriving while busy; collisions are checked against
        // pending after this cycle's SCAN has removed the bit being sent.
        if ((state != IDLE) && spike_strobe) begin
            if ((spike_vec & pending_clr) != '0)
                overrun_n = 1'b1;
            pending_n = pending_clr | spike_vec;
        end

        // Handshake decision uses the merged pending so a strobe landing on the
        // final accept cycle is not lost.
        if ((state == SEND) && pkt_ready) begin
            pkt_valid_n = 1'b0;
            if (pending_n != '0) begin
                state_n = SCAN;
            end else begin
                state_n   = IDLE;
                ts_done_n = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_dispatcher.sv
// Directed self-checking bench for spike_dispatcher (default parameters).
module tb_spike_dispatcher;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        clear;
    logic        spike_strobe;
    logic [7:0]  spike_vec;
    logic [14:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        busy;
    logic        ts_done;
    logic        overrun;
    logic [7:0]  ts_count;

    int total = 0;
    int bad   = 0;

    logic [2:0] got_idx [16];
    logic [7:0] got_ts  [16];
    int         got_n;
    int         got_done;

    spike_dispatcher #(
        .NUM_NEURONS(8),
        .NODE_ID_W  (4),
        .NODE_ID    (0),
        .TS_W       (8)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .clear       (clear),
        .spike_strobe(spike_strobe),
        .spike_vec   (spike_vec),
        .pkt_data    (pkt_data),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .busy        (busy),
        .ts_done     (ts_done),
        .overrun     (overrun),
        .ts_count    (ts_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    // Run a fixed number of cycles, recording every accepted-side packet seen.
    task automatic drain(input int cycles);
        got_n    = 0;
        got_done = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (pkt_valid && got_n < 16) begin
                got_idx[got_n] = pkt_data[2:0];
                got_ts[got_n]  = pkt_data[10:3];
                got_n++;
            end
            if (ts_done) got_done++;
        end
    endtask

    initial begin
        RESET = 1'b1; clear = 1'b0; spike_strobe = 1'b0; spike_vec = '0; pkt_ready = 1'b0;
        tick(); tick();
        @(negedge CLK);
        RESET = 1'b0;
        tick();

        check("rst_valid",   32'(pkt_valid), 32'd0);
        check("rst_data",    32'(pkt_data),  32'd0);
        check("rst_ts",      32'(ts_count),  32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_done",    32'(ts_done),   32'd0);
        check("rst_overrun", 32'(overrun),   32'd0);

        // Empty strobe in IDLE does nothing
        spike_strobe = 1'b1; spike_vec = 8'h00;
        tick();
        spike_strobe = 1'b0;
        check("empty_busy", 32'(busy), 32'd0);
        tick();
        check("empty_done", 32'(ts_done), 32'd0);

        // Three timesteps, then 1001_0010 with ready held high
        clear_pulse(); clear_pulse(); clear_pulse();
        check("ts3", 32'(ts_count), 32'd3);
        pkt_ready = 1'b1;
        spike_strobe = 1'b1; spike_vec = 8'b1001_0010;
        tick();
        spike_strobe = 1'b0;
        check("lat_valid0", 32'(pkt_valid), 32'd0);
        check("lat_busy",   32'(busy),      32'd1);
        tick();
        check("lat_valid1", 32'(pkt_valid), 32'd1);
        check("pkt_idx1",   32'(pkt_data),  32'({4'd0, 8'd3, 3'd1}));
        drain(12);
        check("t2_count", 32'(got_n),    32'd2);
        check("t2_idx4",  32'(got_idx[0]), 32'd4);
        check("t2_idx7",  32'(got_idx[1]), 32'd7);
        check("t2_ts",    32'(got_ts[1]),  32'd3);
        check("t2_done",  32'(got_done),   32'd1);
        check("t2_idle",  32'(busy),       32'd0);

        // Backpressure: SEND held 5 cycles with ready low
        pkt_ready = 1'b0;
        spike_strobe = 1'b1; spike_vec = 8'h20;
        tick();
        spike_strobe = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_valid", 32'(pkt_valid), 32'd1);
            check("bp_data",  32'(pkt_data),  32'({4'd0, 8'd3, 3'd5}));
        end
        pkt_ready = 1'b1;
        tick();
        check("bp_accept", 32'(pkt_valid), 32'd0);
        check("bp_done",   32'(ts_done),   32'd1);
        drain(6);
        check("bp_once", 32'(got_n), 32'd0);

        // Merge: 0x03, then 0x0C while idx0 is in SEND
        spike_strobe = 1'b1; spike_vec = 8'h03;
        tick();
        spike_strobe = 1'b0;
        tick();
        check("mg_idx0", 32'(pkt_data), 32'({4'd0, 8'd3, 3'd0}));
        spike_strobe = 1'b1; spike_vec = 8'h0C;
        tick();
        spike_strobe = 1'b0;
        drain(16);
        check("mg_count",   32'(got_n),      32'd3);
        check("mg_idx1",    32'(got_idx[0]), 32'd1);
        check("mg_idx2",    32'(got_idx[1]), 32'd2);
        check("mg_idx3",    32'(got_idx[2]), 32'd3);
        check("mg_done",    32'(got_done),   32'd1);
        check("mg_overrun", 32'(overrun),    32'd0);

        // Overrun: 0x02 arrives while bit1 still pending
        pkt_ready = 1'b0;
        spike_strobe = 1'b1; spike_vec = 8'h03;
        tick();
        spike_strobe = 1'b0;
        tick();
        spike_strobe = 1'b1; spike_vec = 8'h02;
        tick();
        spike_strobe = 1'b0;
        check("ov_set", 32'(overrun), 32'd1);
        pkt_ready = 1'b1;
        drain(10);
        check("ov_count",  32'(got_n),      32'd1);
        check("ov_idx1",   32'(got_idx[0]), 32'd1);
        check("ov_done",   32'(got_done),   32'd1);
        check("ov_sticky", 32'(overrun),    32'd1);

        // Simultaneous clear rise and strobe at ts_count=5
        clear_pulse(); clear_pulse();
        check("ts5", 32'(ts_count), 32'd5);
        clear = 1'b1; spike_strobe = 1'b1; spike_vec = 8'h80;
        tick();
        clear = 1'b0; spike_strobe = 1'b0;
        check("sim_ts6", 32'(ts_count), 32'd6);
        tick();
        check("sim_pkt", 32'(pkt_data), 32'({4'd0, 8'd5, 3'd7}));
        drain(4);
        check("sim_done", 32'(got_done), 32'd1);

        // clear held high counts once
        clear = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        clear = 1'b0;
        tick();
        check("hold_ts7", 32'(ts_count), 32'd7);

        // Async reset during SEND
        pkt_ready = 1'b0;
        spike_strobe = 1'b1; spike_vec = 8'h10;
        tick();
        spike_strobe = 1'b0;
        tick();
        check("ar_pre_valid", 32'(pkt_valid), 32'd1);
        #2 RESET = 1'b1;
        #1;
        check("ar_valid",   32'(pkt_valid), 32'd0);
        check("ar_data",    32'(pkt_data),  32'd0);
        check("ar_busy",    32'(busy),      32'd0);
        check("ar_overrun", 32'(overrun),   32'd0);
        check("ar_ts",      32'(ts_count),  32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        tick();
        pkt_ready = 1'b1;
        spike_strobe = 1'b1; spike_vec = 8'h08;
        tick();
        spike_strobe = 1'b0;
        tick();
        check("ar_fresh_pkt", 32'(pkt_data), 32'({4'd0, 8'd0, 3'd3}));
        drain(4);
        check("ar_fresh_done", 32'(got_done), 32'd1);

        // Wrap: 255 pulses then one more
        for (int p = 0; p < 255; p++) clear_pulse();
        check("wrap_255", 32'(ts_count), 32'd255);
        clear_pulse();
        check("wrap_0", 32'(ts_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
